// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//
// Purpose:
//   Raster timing generator for the VGA renderer. Walks a pixel/line position
//   one pixel per clock and produces the sync, blanking and strobe signals the
//   pixel-colour logic needs. A frame counter lets animation logic step once
//   per frame. The default geometry is 640x480 @ 60 Hz with a 25.175/25.2 MHz
//   pixel clock.
//
// Ports:
//   clk          in   1   pixel clock, all logic on the rising edge
//   reset        in   1   synchronous, active-high reset
//   hsync        out  1   horizontal sync, active level = !SYNC_NEG
//   vsync        out  1   vertical sync, active level = !SYNC_NEG
//   display_on   out  1   (hpos,vpos) lies inside the visible area
//   hpos         out  10  current column, 0..H_TOTAL-1
//   vpos         out  10  current line, 0..V_TOTAL-1
//   line_start   out  1   high for the single cycle where hpos==0
//   frame_start  out  1   high for the single cycle where hpos==0 and vpos==0
//   vblank       out  1   high while vpos >= V_DISPLAY
//   frame_count  out  8   completed-frame counter, wraps 255->0
// -----------------------------------------------------------------------------
module vga_timing_gen #(
   parameter int H_DISPLAY = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_DISPLAY = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33,
   parameter int SYNC_NEG  = 1
) (
   input  logic       clk,
   input  logic       reset,
   output logic       hsync,
   output logic       vsync,
   output logic       display_on,
   output logic [9:0] hpos,
   output logic [9:0] vpos,
   output logic       line_start,
   output logic       frame_start,
   output logic       vblank,
   output logic [7:0] frame_count
);

   localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

   // Positions are 10 bits wide, so neither total may exceed 1024.
   generate
      if ((H_TOTAL > 1024) || (V_TOTAL > 1024)) begin : gBadTotal
         $error("vga_timing_gen: H_TOTAL and V_TOTAL must both be <= 1024");
      end
   endgenerate

   localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

   // Region boundaries are 11 bits so an end boundary equal to 1024 still
   // compares correctly against a zero-extended 10-bit position.
   localparam logic [10:0] H_VIS_END  = 11'(H_DISPLAY);
   localparam logic [10:0] HS_BEGIN   = 11'(H_DISPLAY + H_FRONT);
   localparam logic [10:0] HS_END     = 11'(H_DISPLAY + H_FRONT + H_SYNC);
   localparam logic [10:0] V_VIS_END  = 11'(V_DISPLAY);
   localparam logic [10:0] VS_BEGIN   = 11'(V_DISPLAY + V_FRONT);
   localparam logic [10:0] VS_END     = 11'(V_DISPLAY + V_FRONT + V_SYNC);

   localparam logic SYNC_ACT = (SYNC_NEG == 0);

   logic [9:0] hpos_q, hpos_d;
   logic [9:0] vpos_q, vpos_d;
   logic [7:0] frame_count_q, frame_count_d;
   logic       hsync_q, hsync_d;
   logic       vsync_q, vsync_d;
   logic       display_on_q, display_on_d;
   logic       line_start_q, line_start_d;
   logic       frame_start_q, frame_start_d;
   logic       vblank_q, vblank_d;
   logic [10:0] hExt, vExt;

   // Position counters and frame counter. The frame counter steps on the same
   // edge on which the raster wraps to (0,0), so its new value is visible
   // together with frame_start.
   always_comb begin
      hpos_d        = hpos_q + 10'd1;
      vpos_d        = vpos_q;
      frame_count_d = frame_count_q;
      if (hpos_q == H_LAST) begin
         hpos_d = '0;
         if (vpos_q == V_LAST) begin
            vpos_d        = '0;
            frame_count_d = frame_count_q + 8'd1;
         end else begin
            vpos_d = vpos_q + 10'd1;
         end
      end
   end

   // All sync/strobe outputs are decoded from the *next* position and then
   // registered alongside it, so every output register describes the same
   // (hpos,vpos) pair in the same cycle with no pipeline skew.
   always_comb begin
      hExt          = {1'b0, hpos_d};
      vExt          = {1'b0, vpos_d};
      hsync_d       = ((hExt >= HS_BEGIN) && (hExt < HS_END)) ? SYNC_ACT : ~SYNC_ACT;
      vsync_d       = ((vExt >= VS_BEGIN) && (vExt < VS_END)) ? SYNC_ACT : ~SYNC_ACT;
      display_on_d  = (hExt < H_VIS_END) && (vExt < V_VIS_END);
      vblank_d      = (vExt >= V_VIS_END);
      line_start_d  = (hpos_d == '0);
      frame_start_d = (hpos_d == '0) && (vpos_d == '0);
   end

   // State register. Reset forces every output to describe position (0,0),
   // which is why the strobes and display_on are high during reset; any sync
   // pulse in progress is cut off on the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         hpos_q        <= '0;
         vpos_q        <= '0;
         frame_count_q <= '0;
         hsync_q       <= ~SYNC_ACT;
         vsync_q       <= ~SYNC_ACT;
         display_on_q  <= 1'b1;
         vblank_q      <= 1'b0;
         line_start_q  <= 1'b1;
         frame_start_q <= 1'b1;
      end else begin
         hpos_q        <= hpos_d;
         vpos_q        <= vpos_d;
         frame_count_q <= frame_count_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         display_on_q  <= display_on_d;
         vblank_q      <= vblank_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign hpos        = hpos_q;
   assign vpos        = vpos_q;
   assign frame_count = frame_count_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign display_on  = display_on_q;
   assign vblank      = vblank_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Three instances share one clock:
//   A - default 640x480 timing
//   B - default horizontal timing, short frame (V 20/3/2/5 = 30 lines)
//   C - tiny geometry (H 4/1/1/1, V 3/1/1/1) with active-high syncs
// A behavioural raster model pushes the expected outputs of every instance
// into a scoreboard queue at each rising edge; they are popped and compared
// on the following falling edge. Directed monitors measure line and frame
// features independently against fixed numbers.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

   typedef struct packed {
      logic       hs;
      logic       vs;
      logic       disp;
      logic [9:0] hp;
      logic [9:0] vp;
      logic       ls;
      logic       fs;
      logic       vb;
      logic [7:0] fc;
   } obs_t;

   typedef struct packed {
      obs_t c;
      obs_t b;
      obs_t a;
   } trio_t;

   localparam int HD[3]  = '{640, 640, 4};
   localparam int HF[3]  = '{16, 16, 1};
   localparam int HS[3]  = '{96, 96, 1};
   localparam int HB[3]  = '{48, 48, 1};
   localparam int VD[3]  = '{480, 20, 3};
   localparam int VF[3]  = '{10, 3, 1};
   localparam int VS[3]  = '{2, 2, 1};
   localparam int VB[3]  = '{33, 5, 1};
   localparam int NEG[3] = '{1, 1, 0};

   logic clk = 1'b0;
   logic rstA = 1'b1;
   logic rstB = 1'b1;
   logic rstC = 1'b1;

   logic       hsA, vsA, dispA, lsA, fsA, vbA;
   logic [9:0] hposA, vposA;
   logic [7:0] fcA;
   logic       hsB, vsB, dispB, lsB, fsB, vbB;
   logic [9:0] hposB, vposB;
   logic [7:0] fcB;
   logic       hsC, vsC, dispC, lsC, fsC, vbC;
   logic [9:0] hposC, vposC;
   logic [7:0] fcC;

   obs_t obsA, obsB, obsC;
   assign obsA = {hsA, vsA, dispA, hposA, vposA, lsA, fsA, vbA, fcA};
   assign obsB = {hsB, vsB, dispB, hposB, vposB, lsB, fsB, vbB, fcB};
   assign obsC = {hsC, vsC, dispC, hposC, vposC, lsC, fsC, vbC, fcC};

   int total = 0;
   int bad   = 0;

   trio_t sbq[$];
   int mh[3];
   int mv[3];
   int mfc[3];

   logic bMon = 1'b0;
   logic cMon = 1'b0;
   logic bDone = 1'b0;
   logic cDone = 1'b0;

   always #5 clk = ~clk;

   vga_timing_gen dutA (
      .clk(clk), .reset(rstA), .hsync(hsA), .vsync(vsA), .display_on(dispA),
      .hpos(hposA), .vpos(vposA), .line_start(lsA), .frame_start(fsA),
      .vblank(vbA), .frame_count(fcA)
   );

   vga_timing_gen #(
      .V_DISPLAY(20), .V_FRONT(3), .V_SYNC(2), .V_BACK(5)
   ) dutB (
      .clk(clk), .reset(rstB), .hsync(hsB), .vsync(vsB), .display_on(dispB),
      .hpos(hposB), .vpos(vposB), .line_start(lsB), .frame_start(fsB),
      .vblank(vbB), .frame_count(fcB)
   );

   vga_timing_gen #(
      .H_DISPLAY(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
      .V_DISPLAY(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .SYNC_NEG(0)
   ) dutC (
      .clk(clk), .reset(rstC), .hsync(hsC), .vsync(vsC), .display_on(dispC),
      .hpos(hposC), .vpos(vposC), .line_start(lsC), .frame_start(fsC),
      .vblank(vbC), .frame_count(fcC)
   );

   // Single comparison point: counts every comparison and reports mismatches.
   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("[TB] FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   // Drives the three resets; changes land on a falling edge so the DUT
   // samples them cleanly on the next rising edge.
   task automatic applyStimulus(input logic a, input logic b, input logic c);
      rstA = a;
      rstB = b;
      rstC = c;
   endtask

   // Expected outputs for instance i at the model's current raster position,
   // written straight from the region definitions.
   function automatic obs_t expOf(input int i);
      obs_t e;
      logic hAct, vAct;
      hAct   = (mh[i] >= HD[i] + HF[i]) && (mh[i] < HD[i] + HF[i] + HS[i]);
      vAct   = (mv[i] >= VD[i] + VF[i]) && (mv[i] < VD[i] + VF[i] + VS[i]);
      e.hs   = hAct ? (NEG[i] == 0) : (NEG[i] != 0);
      e.vs   = vAct ? (NEG[i] == 0) : (NEG[i] != 0);
      e.disp = (mh[i] < HD[i]) && (mv[i] < VD[i]);
      e.hp   = 10'(mh[i]);
      e.vp   = 10'(mv[i]);
      e.ls   = (mh[i] == 0);
      e.fs   = (mh[i] == 0) && (mv[i] == 0);
      e.vb   = (mv[i] >= VD[i]);
      e.fc   = 8'(mfc[i]);
      return e;
   endfunction

   // Reference raster model: steps on each rising edge using the reset value
   // the DUTs sample on that same edge, then queues the expected outputs.
   always @(posedge clk) begin
      logic [2:0] r;
      trio_t t;
      r = {rstC, rstB, rstA};
      for (int i = 0; i < 3; i++) begin
         if (r[i]) begin
            mh[i]  = 0;
            mv[i]  = 0;
            mfc[i] = 0;
         end else if (mh[i] == HD[i] + HF[i] + HS[i] + HB[i] - 1) begin
            mh[i] = 0;
            if (mv[i] == VD[i] + VF[i] + VS[i] + VB[i] - 1) begin
               mv[i]  = 0;
               mfc[i] = (mfc[i] + 1) % 256;
            end else begin
               mv[i] = mv[i] + 1;
            end
         end else begin
            mh[i] = mh[i] + 1;
         end
      end
      t.a = expOf(0);
      t.b = expOf(1);
      t.c = expOf(2);
      sbq.push_back(t);
   end

   // Scoreboard drain: each rising edge must have produced exactly one entry.
   always @(negedge clk) begin
      trio_t e;
      if (sbq.size() > 1) checkOutput("sbDepth", 64'(sbq.size()), 64'd1);
      if (sbq.size() > 0) begin
         e = sbq.pop_front();
         checkOutput("sbA", 64'(obsA), 64'(e.a));
         checkOutput("sbB", 64'(obsB), 64'(e.b));
         checkOutput("sbC", 64'(obsC), 64'(e.c));
      end
   end

   // Frame statistics on instance B over its first frame after release,
   // ending on the frame_start that closes it.
   int   bCyc = 0, visPix = 0, vsLow = 0, syncInDisp = 0;
   int   vsStartH = -1, vsStartV = -1, vbRiseH = -1, vbRiseV = -1;
   int   fsAt = -1, fcAtFs = -1;
   logic prevVsB = 1'b1, prevVbB = 1'b0;
   always @(negedge clk) begin
      if (bMon && !bDone) begin
         bCyc++;
         if (dispB) visPix++;
         if (!vsB) vsLow++;
         if (dispB && (!hsB || !vsB)) syncInDisp++;
         if (prevVsB && !vsB && vsStartH < 0) begin
            vsStartH = hposB;
            vsStartV = vposB;
         end
         if (!prevVbB && vbB && vbRiseH < 0) begin
            vbRiseH = hposB;
            vbRiseV = vposB;
         end
         prevVsB = vsB;
         prevVbB = vbB;
         if (fsB) begin
            fsAt   = bCyc;
            fcAtFs = fcB;
            bDone  = 1'b1;
         end
      end
   end

   // Frame-counter wrap and sync polarity on instance C. The k-th frame_start
   // after release must carry frame_count == k mod 256.
   int   cFrames = 0, cCyc = 0, cLastFs = -1;
   logic cPeriodDone = 1'b0, cHsDone = 1'b0, cVsDone = 1'b0;
   always @(negedge clk) begin
      if (cMon && !cDone) begin
         cCyc++;
         if (!cHsDone && hposC == 10'd5) begin
            checkOutput("cHsyncActiveHigh", 64'(hsC), 64'd1);
            cHsDone = 1'b1;
         end
         if (!cVsDone && vposC == 10'd4) begin
            checkOutput("cVsyncActiveHigh", 64'(vsC), 64'd1);
            cVsDone = 1'b1;
         end
         if (fsC) begin
            cFrames++;
            if (cLastFs >= 0 && !cPeriodDone) begin
               checkOutput("cFramePeriod", 64'(cCyc - cLastFs), 64'd42);
               cPeriodDone = 1'b1;
            end
            cLastFs = cCyc;
            if (cFrames == 255) checkOutput("cFc255", 64'(fcC), 64'd255);
            if (cFrames == 256) checkOutput("cFcWrap0", 64'(fcC), 64'd0);
            if (cFrames == 257) begin
               checkOutput("cFcWrap1", 64'(fcC), 64'd1);
               cDone = 1'b1;
            end
         end
      end
   end

   // Main sequence: reset, first line on A, then frame/wrap results, then a
   // one-clock mid-frame reset on B.
   initial begin
      int   hsFall, hsRise, dispFall, hsLow0, lsLast, lsPeriod;
      int   prevH, prevV, wrapH, wrapV, wrapPrevV;
      logic prevHs, prevDisp, wrapSeen, found;

      applyStimulus(1'b1, 1'b1, 1'b1);
      repeat (3) @(negedge clk);
      checkOutput("rstHpos", 64'(hposA), 64'd0);
      checkOutput("rstVpos", 64'(vposA), 64'd0);
      checkOutput("rstDisp", 64'(dispA), 64'd1);
      checkOutput("rstHsync", 64'(hsA), 64'd1);
      checkOutput("rstVsync", 64'(vsA), 64'd1);
      checkOutput("rstFrameStart", 64'(fsA), 64'd1);
      checkOutput("rstLineStart", 64'(lsA), 64'd1);
      checkOutput("rstVblank", 64'(vbA), 64'd0);
      checkOutput("rstFc", 64'(fcA), 64'd0);
      checkOutput("rstHsyncC", 64'(hsC), 64'd0);

      applyStimulus(1'b0, 1'b0, 1'b0);
      @(posedge clk);
      bMon = 1'b1;
      cMon = 1'b1;
      @(negedge clk);
      checkOutput("relHpos", 64'(hposA), 64'd1);
      checkOutput("relFrameStart", 64'(fsA), 64'd0);
      checkOutput("relLineStart", 64'(lsA), 64'd0);

      // First lines of the default instance.
      hsFall = -1; hsRise = -1; dispFall = -1; hsLow0 = 0;
      lsLast = -1; lsPeriod = -1; wrapSeen = 1'b0;
      wrapH = -1; wrapV = -1; wrapPrevV = -1;
      prevHs = hsA; prevDisp = dispA; prevH = hposA; prevV = vposA;
      for (int c = 1; c <= 1700; c++) begin
         @(negedge clk);
         if (prevHs && !hsA && hsFall < 0) hsFall = hposA;
         if (!prevHs && hsA && hsRise < 0) hsRise = hposA;
         if (prevDisp && !dispA && dispFall < 0) dispFall = hposA;
         if (!hsA && vposA == 10'd0) hsLow0++;
         if (lsA) begin
            if (lsLast >= 0 && lsPeriod < 0) lsPeriod = c - lsLast;
            lsLast = c;
         end
         if (prevH == 799 && !wrapSeen) begin
            wrapSeen  = 1'b1;
            wrapH     = hposA;
            wrapV     = vposA;
            wrapPrevV = prevV;
         end
         prevHs = hsA; prevDisp = dispA; prevH = hposA; prevV = vposA;
      end
      checkOutput("hsyncFallAt", 64'(hsFall), 64'd656);
      checkOutput("hsyncRiseAt", 64'(hsRise), 64'd752);
      checkOutput("hsyncLowLen", 64'(hsLow0), 64'd96);
      checkOutput("dispFallAt", 64'(dispFall), 64'd640);
      checkOutput("lineStartPeriod", 64'(lsPeriod), 64'd800);
      checkOutput("wrapSeen", 64'(wrapSeen), 64'd1);
      checkOutput("wrapHpos", 64'(wrapH), 64'd0);
      checkOutput("wrapVpos", 64'(wrapV), 64'(wrapPrevV + 1));

      // Wait for the B frame and C wrap monitors, with a bound.
      for (int i = 0; i < 30000 && !(bDone && cDone); i++) @(negedge clk);
      checkOutput("bFrameDone", 64'(bDone), 64'd1);
      checkOutput("cWrapDone", 64'(cDone), 64'd1);
      checkOutput("bFramePeriod", 64'(fsAt), 64'd24000);
      checkOutput("bFcAtFrameStart", 64'(fcAtFs), 64'd1);
      checkOutput("bVisiblePixels", 64'(visPix), 64'd12800);
      checkOutput("bVsyncLowLen", 64'(vsLow), 64'd1600);
      checkOutput("bVsyncStartH", 64'(vsStartH), 64'd0);
      checkOutput("bVsyncStartV", 64'(vsStartV), 64'd23);
      checkOutput("bVblankRiseH", 64'(vbRiseH), 64'd0);
      checkOutput("bVblankRiseV", 64'(vbRiseV), 64'd20);
      checkOutput("bSyncInDisplay", 64'(syncInDisp), 64'd0);

      // One-clock reset on B while it sits at (700,10), inside a line.
      found = 1'b0;
      for (int i = 0; i < 30000 && !found; i++) begin
         @(negedge clk);
         if (hposB == 10'd700 && vposB == 10'd10) found = 1'b1;
      end
      checkOutput("bFoundMidFrame", 64'(found), 64'd1);
      applyStimulus(1'b0, 1'b1, 1'b0);
      @(negedge clk);
      checkOutput("midRstHpos", 64'(hposB), 64'd0);
      checkOutput("midRstVpos", 64'(vposB), 64'd0);
      checkOutput("midRstHsync", 64'(hsB), 64'd1);
      checkOutput("midRstLineStart", 64'(lsB), 64'd1);
      checkOutput("midRstFrameStart", 64'(fsB), 64'd1);
      checkOutput("midRstFc", 64'(fcB), 64'd0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      repeat (800) @(negedge clk);
      checkOutput("postRstHpos", 64'(hposB), 64'd0);
      checkOutput("postRstVpos", 64'(vposB), 64'd1);
      checkOutput("postRstLineStart", 64'(lsB), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Upstream stage of the VGA renderer. It produces the raster scan position and the sync/blanking signals that the pixel-colour logic consumes: hsync, vsync, display_on, hpos and vpos.
- It also provides per-line and per-frame strobes and a frame counter, so downstream animation logic can step once per frame instead of using a free-running divider.
- Default timing is 640x480 @ 60 Hz on a 25.175/25.2 MHz pixel clock; one clock equals one pixel.

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_NEG, 1, 1 = syncs active-low, 0 = active-high

Ports:
- clk  in  1  pixel clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- hsync  out  1  horizontal sync, polarity per SYNC_NEG
- vsync  out  1  vertical sync, polarity per SYNC_NEG
- display_on  out  1  high when (hpos,vpos) is in the visible area
- hpos  out  10  current column, 0..H_TOTAL-1
- vpos  out  10  current line, 0..V_TOTAL-1
- line_start  out  1  high for the one clock where hpos==0
- frame_start  out  1  high for the one clock where hpos==0 and vpos==0
- vblank  out  1  high while vpos >= V_DISPLAY
- frame_count  out  8  completed-frame counter, wraps 255->0

Behaviour:
- Derived constants: H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK (525). Both must be <= 1024, enforced by an elaboration check.
- All outputs are registered. In every cycle, every output describes the same (hpos,vpos) pair: no skew between the counters and the sync/strobe signals.
- hpos advances by 1 every clock. At H_TOTAL-1 it wraps to 0 and vpos advances by 1. At (H_TOTAL-1, V_TOTAL-1) both wrap to 0.
- Sync active regions:
  - hsync active for H_DISPLAY+H_FRONT <= hpos < H_DISPLAY+H_FRONT+H_SYNC (656..751).
  - vsync active for V_DISPLAY+V_FRONT <= vpos < V_DISPLAY+V_FRONT+V_SYNC (490..491), for the entire lines.
- Output level: active level = !SYNC_NEG, inactive level = SYNC_NEG.
- display_on = (hpos < H_DISPLAY) && (vpos < V_DISPLAY).
- vblank = (vpos >= V_DISPLAY), over whole lines.
- frame_count increments on the same clock edge on which the counters wrap from (H_TOTAL-1, V_TOTAL-1) to (0,0). Its new value therefore appears in the same cycle that frame_start is high; 8-bit wrap.
- Reset values: hpos=0, vpos=0, display_on=1, hsync=vsync=inactive (1 with default SYNC_NEG), line_start=1, frame_start=1, vblank=0, frame_count=0.
  - Strobes are 1 during reset because outputs describe position (0,0).
- Reset asserted mid-frame: on the next edge, all outputs take their reset values; no partial sync pulse is extended. The first cycle after release is hpos=1, vpos=0.
- Reset held for N cycles: outputs stay at their reset values; frame_count does not advance.
- No clock enable and no other inputs. The block free-runs out of reset.

Test Plan:
- Reset for 3 clocks, release -> during reset hpos=0, vpos=0, display_on=1, hsync=vsync=1, frame_start=1, frame_count=0; first post-release cycle hpos=1, frame_start=0, line_start=0.
- Run one line -> hsync falls at hpos=656 and rises at hpos=752 (96 clocks low); display_on falls at hpos=640; line_start pulses exactly every 800 clocks; hpos 799 is followed by 0 with vpos+1.
- Run one full frame -> vsync low for exactly 1600 clocks, starting at (0,490); vblank rises at (0,480); frame_start pulses every 420000 clocks with frame_count 0->1 in that same cycle.
- Throughout the frame, assert display_on == (hpos<640 && vpos<480) and no sync active while display_on=1; count visible pixels = 307200.
- Small override (H: 4/1/1/1, V: 3/1/1/1, SYNC_NEG=0), run 257 frames -> active-high syncs; frame_count reaches 255 then wraps to 0, then 1.
- Assert reset at (700,300) for 1 clock -> next cycle outputs equal reset values; 800 clocks later vpos=1, hpos=0, line_start=1.
